// File: rtl/doce_rx_frame_filter.sv
// ---------------------------------------------------------------------------
// doce_rx_frame_filter
//
// Ingress filter that sits between the Ethernet MAC Rx stream and the DoCE
// transport layer Rx input. The first beat of each frame carries the whole
// Ethernet header. That beat decides whether the frame is forwarded or
// silently discarded. A frame is forwarded when the destination MAC is the
// local address or broadcast, and the EtherType is the DoCE EtherType.
// Forwarded beats go through one output register, so latency is one cycle.
// Saturating counters report how many frames were passed and dropped.
//
// Parameters
//   DATA_WIDTH      stream width in bytes (16 or 32; the 14-byte header
//                   must arrive in the first beat)
//   DOCE_ETHERTYPE  EtherType accepted as DoCE traffic
//
// Ports
//   clk, reset               single clock, synchronous active-high reset
//   doce_mac_addr            local MAC, [47:40] is the first byte on the wire
//   filter_en                1 = filter active, 0 = forward every frame
//   mac_axis_rxd_*           AXI-Stream input from the MAC (byte 0 in [7:0])
//   doce_axis_rxd_*          AXI-Stream output to the transport layer
//   rx_pass_cnt/rx_drop_cnt  saturating frame counters
// ---------------------------------------------------------------------------
module doce_rx_frame_filter #(
  parameter int          DATA_WIDTH     = 16,
  parameter logic [15:0] DOCE_ETHERTYPE = 16'h88B5
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [47:0]               doce_mac_addr,
  input  logic                      filter_en,
  input  logic [DATA_WIDTH*8-1:0]   mac_axis_rxd_tdata,
  input  logic [DATA_WIDTH-1:0]     mac_axis_rxd_tkeep,
  input  logic                      mac_axis_rxd_tlast,
  input  logic                      mac_axis_rxd_tvalid,
  output logic                      mac_axis_rxd_tready,
  output logic [DATA_WIDTH*8-1:0]   doce_axis_rxd_tdata,
  output logic [DATA_WIDTH-1:0]     doce_axis_rxd_tkeep,
  output logic                      doce_axis_rxd_tlast,
  output logic                      doce_axis_rxd_tvalid,
  input  logic                      doce_axis_rxd_tready,
  output logic [31:0]               rx_pass_cnt,
  output logic [31:0]               rx_drop_cnt
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PASS = 2'd1,
    DROP = 2'd2
  } state_e;

  state_e                    state_q, state_d;
  logic                      mout_valid_q, mout_valid_d;
  logic [DATA_WIDTH*8-1:0]   mout_data_q, mout_data_d;
  logic [DATA_WIDTH-1:0]     mout_keep_q, mout_keep_d;
  logic                      mout_last_q, mout_last_d;
  logic [31:0]               rx_pass_cnt_q, rx_pass_cnt_d;
  logic [31:0]               rx_drop_cnt_q, rx_drop_cnt_d;

  logic [47:0] hdr_dst;
  logic [15:0] hdr_etype;
  logic        hdr_bcast;
  logic        hdr_runt;
  logic        frame_match;
  logic        beat_accept;
  logic        mout_load;
  logic        pass_inc;
  logic        drop_inc;

  // Header fields of the current beat; only meaningful on a first beat (IDLE).
  // Byte 0 of the stream is the most significant byte of the MAC address.
  assign hdr_dst   = {mac_axis_rxd_tdata[7:0],   mac_axis_rxd_tdata[15:8],
                      mac_axis_rxd_tdata[23:16], mac_axis_rxd_tdata[31:24],
                      mac_axis_rxd_tdata[39:32], mac_axis_rxd_tdata[47:40]};
  assign hdr_etype = {mac_axis_rxd_tdata[103:96], mac_axis_rxd_tdata[111:104]};
  assign hdr_bcast = (hdr_dst == 48'hFFFF_FFFF_FFFF);
  // A single-beat frame that ends before the EtherType is complete.
  assign hdr_runt  = mac_axis_rxd_tlast & ~mac_axis_rxd_tkeep[13];

  assign frame_match = filter_en
                     ? (~hdr_runt
                        & ((hdr_dst == doce_mac_addr) | hdr_bcast)
                        & (hdr_etype == DOCE_ETHERTYPE))
                     : 1'b1;

  // DROP swallows beats unconditionally; otherwise accept only when the
  // output register is empty or draining this cycle.
  assign mac_axis_rxd_tready = (state_q == DROP) | ~mout_valid_q | doce_axis_rxd_tready;
  assign beat_accept         = mac_axis_rxd_tvalid & mac_axis_rxd_tready;
  assign mout_load           = beat_accept
                             & (((state_q == IDLE) & frame_match) | (state_q == PASS));

  // NOTE: every variable gets a default before any branch, so no path leaves
  // a signal unassigned and no latch is inferred.
  always_comb begin
    state_d  = state_q;
    pass_inc = 1'b0;
    drop_inc = 1'b0;
    if (beat_accept) begin
      case (state_q)
        IDLE: begin
          if (frame_match) begin
            if (mac_axis_rxd_tlast) pass_inc = 1'b1;
            else                    state_d  = PASS;
          end else begin
            if (mac_axis_rxd_tlast) drop_inc = 1'b1;
            else                    state_d  = DROP;
          end
        end
        PASS: begin
          if (mac_axis_rxd_tlast) begin
            pass_inc = 1'b1;
            state_d  = IDLE;
          end
        end
        DROP: begin
          if (mac_axis_rxd_tlast) begin
            drop_inc = 1'b1;
            state_d  = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Output register: a new beat wins over a simultaneous drain, so tvalid
  // stays high across back-to-back beats.
  always_comb begin
    mout_valid_d = mout_valid_q;
    mout_data_d  = mout_data_q;
    mout_keep_d  = mout_keep_q;
    mout_last_d  = mout_last_q;
    if (mout_load) begin
      mout_valid_d = 1'b1;
      mout_data_d  = mac_axis_rxd_tdata;
      mout_keep_d  = mac_axis_rxd_tkeep;
      mout_last_d  = mac_axis_rxd_tlast;
    end else if (doce_axis_rxd_tready) begin
      mout_valid_d = 1'b0;
    end
  end

  always_comb begin
    rx_pass_cnt_d = rx_pass_cnt_q;
    rx_drop_cnt_d = rx_drop_cnt_q;
    if (pass_inc && (rx_pass_cnt_q != 32'hFFFF_FFFF)) rx_pass_cnt_d = rx_pass_cnt_q + 32'd1;
    if (drop_inc && (rx_drop_cnt_q != 32'hFFFF_FFFF)) rx_drop_cnt_d = rx_drop_cnt_q + 32'd1;
  end

  // NOTE: state is updated with non-blocking assignments only, so every flop
  // samples the pre-edge value of every other flop.
  always_ff @(posedge clk) begin
    if (reset) begin
      // NOTE: the data path is cleared too, because the output bus itself
      // must read zero after reset, not just tvalid.
      state_q       <= IDLE;
      mout_valid_q  <= 1'b0;
      mout_data_q   <= '0;
      mout_keep_q   <= '0;
      mout_last_q   <= 1'b0;
      rx_pass_cnt_q <= '0;
      rx_drop_cnt_q <= '0;
    end else begin
      state_q       <= state_d;
      mout_valid_q  <= mout_valid_d;
      mout_data_q   <= mout_data_d;
      mout_keep_q   <= mout_keep_d;
      mout_last_q   <= mout_last_d;
      rx_pass_cnt_q <= rx_pass_cnt_d;
      rx_drop_cnt_q <= rx_drop_cnt_d;
    end
  end

  assign doce_axis_rxd_tvalid = mout_valid_q;
  assign doce_axis_rxd_tdata  = mout_data_q;
  assign doce_axis_rxd_tkeep  = mout_keep_q;
  assign doce_axis_rxd_tlast  = mout_last_q;
  assign rx_pass_cnt          = rx_pass_cnt_q;
  assign rx_drop_cnt          = rx_drop_cnt_q;

endmodule

// File: tb/tb_doce_rx_frame_filter.sv
// ---------------------------------------------------------------------------
// tb_doce_rx_frame_filter
//
// Randomized bench for doce_rx_frame_filter. Frames are built from a header
// recipe, and a frame-level reference model classifies each one. Expected
// output beats are queued, and a monitor compares every beat the sink takes.
// The bench also checks one-cycle latency, stability under backpressure,
// full rate with no backpressure, counters, reset and saturation.
// ---------------------------------------------------------------------------
module tb_doce_rx_frame_filter;

  localparam int          DW  = 16;
  localparam logic [15:0] ET  = 16'h88B5;
  localparam logic [47:0] MAC = 48'h0A0B_0C0D_0E0F;

  typedef struct {
    logic [DW*8-1:0] data;
    logic [DW-1:0]   keep;
    logic            last;
  } beat_t;

  typedef enum int {K_UNI, K_BCAST, K_BAD_DST, K_BAD_ET, K_RUNT} kind_e;

  logic            clk = 1'b0;
  logic            reset;
  logic [47:0]     doce_mac_addr;
  logic            filter_en;
  logic [DW*8-1:0] m_tdata;
  logic [DW-1:0]   m_tkeep;
  logic            m_tlast, m_tvalid, m_tready;
  logic [DW*8-1:0] d_tdata;
  logic [DW-1:0]   d_tkeep;
  logic            d_tlast, d_tvalid, d_tready;
  logic [31:0]     pass_cnt, drop_cnt;

  int          n_checks = 0;
  int          n_fail   = 0;
  beat_t       exp_q[$];
  logic [31:0] exp_pass, exp_drop;
  int          sink_mode;  // 0 always ready, 1 pattern 1,0,0,1, 2 random

  doce_rx_frame_filter #(.DATA_WIDTH(DW), .DOCE_ETHERTYPE(ET)) dut (
    .clk                  (clk),
    .reset                (reset),
    .doce_mac_addr        (doce_mac_addr),
    .filter_en            (filter_en),
    .mac_axis_rxd_tdata   (m_tdata),
    .mac_axis_rxd_tkeep   (m_tkeep),
    .mac_axis_rxd_tlast   (m_tlast),
    .mac_axis_rxd_tvalid  (m_tvalid),
    .mac_axis_rxd_tready  (m_tready),
    .doce_axis_rxd_tdata  (d_tdata),
    .doce_axis_rxd_tkeep  (d_tkeep),
    .doce_axis_rxd_tlast  (d_tlast),
    .doce_axis_rxd_tvalid (d_tvalid),
    .doce_axis_rxd_tready (d_tready),
    .rx_pass_cnt          (pass_cnt),
    .rx_drop_cnt          (drop_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [DW*8-1:0] got, input logic [DW*8-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Frame classification straight from the header rules.
  function automatic logic model_match(input beat_t b, input logic fe, input logic [47:0] mac);
    logic [7:0]  by [DW];
    logic [47:0] dst;
    logic [15:0] et;
    logic        runt;
    for (int i = 0; i < DW; i++) by[i] = b.data[8*i +: 8];
    dst = '0;
    for (int i = 0; i < 6; i++) dst = {dst[39:0], by[i]};
    et   = {by[12], by[13]};
    runt = b.last && (b.keep[13] == 1'b0);
    if (!fe) return 1'b1;
    return !runt && (dst == mac || dst == 48'hFFFF_FFFF_FFFF) && et == ET;
  endfunction

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  task automatic make_frame(input kind_e kind, input int n, output beat_t fb [8]);
    logic [47:0] dst;
    logic [15:0] et;
    int          cnt;
    dst = MAC;
    et  = ET;
    case (kind)
      K_BCAST:   dst = 48'hFFFF_FFFF_FFFF;
      K_BAD_DST: dst = {$urandom, $urandom} & 48'hFEFF_FFFF_FFFF;
      K_BAD_ET:  et  = ($urandom_range(1, 0) != 0) ? 16'h0800 : 16'h88B6;
      default:   ;
    endcase
    for (int i = 0; i < 8; i++) begin
      fb[i].data = {$urandom, $urandom, $urandom, $urandom};
      fb[i].keep = '1;
      fb[i].last = (i == n - 1);
    end
    for (int i = 0; i < 6; i++) fb[0].data[8*i +: 8] = dst[47-8*i -: 8];
    fb[0].data[103:96]  = et[15:8];
    fb[0].data[111:104] = et[7:0];
    cnt = (kind == K_RUNT) ? 12 : $urandom_range(16, 1);
    fb[n-1].keep = 16'hFFFF >> (16 - cnt);
  endtask

  // Drives one frame; abort_at >= 0 stops before driving that beat.
  task automatic send_frame(input beat_t fb [8], input int n, input logic fe,
                            input int gap_pct, input int abort_at);
    logic ok;
    int   budget;
    ok = model_match(fb[0], fe, doce_mac_addr);
    for (int i = 0; i < n; i++) begin
      if (i == abort_at) return;
      while (int'($urandom_range(99, 0)) < gap_pct) begin
        m_tvalid = 1'b0;
        @(posedge clk); #1;
      end
      m_tdata   = fb[i].data;
      m_tkeep   = fb[i].keep;
      m_tlast   = fb[i].last;
      m_tvalid  = 1'b1;
      filter_en = (i == 0) ? fe : 1'($urandom_range(1, 0));
      budget = 0;
      forever begin
        @(negedge clk);
        if (sink_mode == 0) check("full_rate_tready", m_tready, 1'b1);
        if (m_tready) break;
        budget++;
        if (budget > 200) begin
          check("accept_timeout", 1'b0, 1'b1);
          break;
        end
      end
      if (ok) exp_q.push_back(fb[i]);
      if (i == n - 1) begin
        if (ok) exp_pass = sat_inc(exp_pass);
        else    exp_drop = sat_inc(exp_drop);
      end
      @(posedge clk); #1;
      if (ok) begin
        check("latency_valid", d_tvalid, 1'b1);
        check("latency_data", d_tdata, fb[i].data);
      end
      if (i == n - 1) begin
        check("pass_cnt", pass_cnt, exp_pass);
        check("drop_cnt", drop_cnt, exp_drop);
      end
    end
    m_tvalid = 1'b0;
  endtask

  // Sink ready generator.
  initial begin
    int ph;
    ph = 0;
    d_tready = 1'b1;
    forever begin
      @(posedge clk); #1;
      case (sink_mode)
        0:       d_tready = 1'b1;
        1:       begin d_tready = (ph == 0 || ph == 3); ph = (ph + 1) % 4; end
        default: d_tready = 1'($urandom_range(1, 0));
      endcase
    end
  end

  // Output monitor: scoreboard compare and stall stability.
  initial begin
    beat_t e;
    beat_t held;
    logic  stalled;
    stalled = 1'b0;
    forever begin
      @(negedge clk);
      if (reset) begin
        stalled = 1'b0;
        continue;
      end
      if (stalled) begin
        check("stall_valid", d_tvalid, 1'b1);
        check("stall_data", d_tdata, held.data);
        check("stall_keep_last", {d_tkeep, d_tlast}, {held.keep, held.last});
      end
      if (d_tvalid && d_tready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_beat", d_tdata, '0);
        end else begin
          e = exp_q.pop_front();
          check("out_data", d_tdata, e.data);
          check("out_keep", d_tkeep, e.keep);
          check("out_last", d_tlast, e.last);
        end
      end
      stalled   = d_tvalid && !d_tready;
      held.data = d_tdata;
      held.keep = d_tkeep;
      held.last = d_tlast;
    end
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic do_reset();
    reset    = 1'b1;
    m_tvalid = 1'b0;
    @(posedge clk); #1;
    check("rst_tvalid", d_tvalid, 1'b0);
    check("rst_tdata", d_tdata, '0);
    check("rst_tkeep_tlast", {d_tkeep, d_tlast}, '0);
    check("rst_pass_cnt", pass_cnt, 32'd0);
    check("rst_drop_cnt", drop_cnt, 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    exp_q.delete();
    exp_pass = '0;
    exp_drop = '0;
    check("rst_mac_tready", m_tready, 1'b1);
  endtask

  initial begin
    beat_t fb [8];
    int    n;
    int    budget;
    kind_e k;
    sink_mode     = 0;
    doce_mac_addr = MAC;
    filter_en     = 1'b1;
    m_tdata       = '0;
    m_tkeep       = '0;
    m_tlast       = 1'b0;
    m_tvalid      = 1'b0;
    @(posedge clk); #1;
    do_reset();

    // Directed: unicast, reject by EtherType and by address, broadcast.
    make_frame(K_UNI, 3, fb);     send_frame(fb, 3, 1'b1, 0, -1);
    make_frame(K_BAD_ET, 4, fb);  send_frame(fb, 4, 1'b1, 0, -1);
    make_frame(K_BAD_DST, 4, fb); send_frame(fb, 4, 1'b1, 0, -1);
    make_frame(K_BCAST, 2, fb);   send_frame(fb, 2, 1'b1, 0, -1);
    // Runt (tkeep 0FFF) then single full beat.
    make_frame(K_RUNT, 1, fb);    send_frame(fb, 1, 1'b1, 0, -1);
    make_frame(K_UNI, 1, fb);     fb[0].keep = '1; send_frame(fb, 1, 1'b1, 0, -1);
    // Filter disabled passes a non-DoCE frame.
    make_frame(K_BAD_ET, 4, fb);  send_frame(fb, 4, 1'b0, 0, -1);
    // Patterned backpressure on an 8-beat frame.
    sink_mode = 1;
    make_frame(K_UNI, 8, fb);     send_frame(fb, 8, 1'b1, 0, -1);

    // Random traffic under random backpressure and idle gaps.
    sink_mode = 2;
    for (int f = 0; f < 150; f++) begin
      k = kind_e'($urandom_range(4, 0));
      n = (k == K_RUNT) ? 1 : int'($urandom_range(8, 1));
      make_frame(k, n, fb);
      send_frame(fb, n, 1'($urandom_range(3, 0) != 0), 30, -1);
    end

    // Back-to-back frames with an always-ready sink at full rate.
    sink_mode = 0;
    @(posedge clk); #1;
    for (int f = 0; f < 40; f++) begin
      k = kind_e'($urandom_range(3, 0));
      n = int'($urandom_range(8, 1));
      make_frame(k, n, fb);
      send_frame(fb, n, 1'b1, 0, -1);
    end

    // Reset in the middle of a forwarded frame, then a clean frame.
    make_frame(K_UNI, 8, fb);
    send_frame(fb, 8, 1'b1, 0, 3);
    do_reset();
    make_frame(K_UNI, 4, fb);     send_frame(fb, 4, 1'b1, 0, -1);

    // Pass counter saturation.
    force dut.rx_pass_cnt_q = 32'hFFFF_FFFE;
    #1;
    release dut.rx_pass_cnt_q;
    exp_pass = 32'hFFFF_FFFE;
    for (int f = 0; f < 3; f++) begin
      make_frame(K_UNI, 2, fb);
      send_frame(fb, 2, 1'b1, 0, -1);
    end
    check("pass_cnt_saturated", pass_cnt, 32'hFFFF_FFFF);

    budget = 0;
    while (exp_q.size() != 0 && budget < 100) begin
      @(posedge clk); #1;
      budget++;
    end
    check("drain_empty", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
